// File: rtl/microcode_uart_loader_pkg.sv
// Shared types and helpers for the microcode UART loader: loader state encoding
// and word/byte sizing helpers.
package microcode_uart_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    WRITE,
    CHECK,
    DONE,
    ERROR
  } loader_state_t;

  localparam int BYTE_W = 8;

  function automatic int word_bytes(input int data_width);
    return data_width / BYTE_W;
  endfunction

  function automatic int index_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/microcode_uart_loader_byte_timer.sv
// Inter-byte watchdog: counts idle cycles while enabled and flags expiry on the
// TIMEOUT-th consecutive cycle without a clear. TIMEOUT = 0 disables it.
module loader_byte_timer #(
  parameter int TIMEOUT = 100000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  logic [CW-1:0] count;

  always_ff @(posedge clock) begin
    if (reset || clear || !enable) begin
      count <= '0;
    end else if (count != LAST) begin
      count <= count + CW'(1);
    end
  end

  // count holds the number of idle cycles already elapsed, so the cycle that
  // sees LAST is the TIMEOUT-th idle cycle.
  assign expire = (TIMEOUT != 0) && enable && !clear && (count == LAST);

endmodule

// File: rtl/microcode_uart_loader.sv
// Loads a framed microcode image from a byte stream into the micro memory write
// port, assembling words MSB-byte-first, and releases cpu_hold once the checksum is good.
module microcode_uart_loader
  import microcode_uart_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 88,
  parameter int ADDR_WIDTH = 9,
  parameter int TIMEOUT    = 100000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_we,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic [2:0]            state_dbg
);

  localparam int BYTES = word_bytes(DATA_WIDTH);
  localparam int IW    = index_width(BYTES);
  localparam logic [IW-1:0] LAST_BYTE = IW'(BYTES - 1);
  localparam logic [16:0]   MAX_WORDS = 17'(2 ** ADDR_WIDTH);

  loader_state_t state, state_next;

  logic [ADDR_WIDTH-1:0] addr;
  logic [7:0]            len_hi;
  logic [15:0]           len;
  logic [IW-1:0]         byte_idx;
  logic [DATA_WIDTH-1:0] word;
  logic [7:0]            sum;

  logic                  accept;
  logic                  expire;
  logic                  timed;
  logic                  idle_like;
  logic [15:0]           len_rx;
  logic [DATA_WIDTH-1:0] word_shifted;
  logic                  more_words;
  logic                  sum_ok;

  // Handshake: a byte transfers on a cycle where rx_valid and rx_ready are both
  // high; rx_ready depends only on the current state, never on rx_valid.
  assign accept       = rx_valid & rx_ready;
  assign len_rx       = {len_hi, rx_data};
  assign word_shifted = (word << 8) | DATA_WIDTH'(rx_data);
  assign more_words   = (17'(word_count) + 17'd1) < {1'b0, len};
  assign sum_ok       = (sum + rx_data) == 8'd0;

  assign timed     = state inside {LEN_LO, DATA, WRITE, CHECK};
  assign idle_like = state inside {IDLE, DONE, ERROR};
  assign busy      = state inside {LEN_HI, LEN_LO, DATA, WRITE, CHECK};
  assign done      = (state == DONE);
  assign error     = (state == ERROR);
  assign cpu_hold  = (state != DONE);
  assign state_dbg = state;

  loader_byte_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clock (clock),
    .reset (reset),
    .clear (accept | ~timed),
    .enable(timed),
    .expire(expire)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    rx_ready   = 1'b0;
    case (state)
      IDLE, DONE, ERROR: begin
        if (start) state_next = LEN_HI;
      end
      LEN_HI: begin
        rx_ready = 1'b1;
        if (rx_valid) state_next = LEN_LO;
      end
      LEN_LO: begin
        rx_ready = 1'b1;
        if (accept) begin
          if (len_rx == 16'd0)                state_next = CHECK;
          else if ({1'b0, len_rx} > MAX_WORDS) state_next = ERROR;
          else                                 state_next = DATA;
        end else if (expire) begin
          state_next = ERROR;
        end
      end
      DATA: begin
        rx_ready = 1'b1;
        if (accept) begin
          if (byte_idx == LAST_BYTE) state_next = WRITE;
        end else if (expire) begin
          state_next = ERROR;
        end
      end
      WRITE: begin
        if (expire)          state_next = ERROR;
        else if (more_words) state_next = DATA;
        else                 state_next = CHECK;
      end
      CHECK: begin
        rx_ready = 1'b1;
        if (accept)      state_next = sum_ok ? DONE : ERROR;
        else if (expire) state_next = ERROR;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      addr        <= '0;
      len_hi      <= '0;
      len         <= '0;
      byte_idx    <= '0;
      word        <= '0;
      sum         <= '0;
      word_count  <= '0;
      mem_address <= '0;
      mem_data    <= '0;
      mem_we      <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      if (idle_like && start) begin
        addr       <= '0;
        byte_idx   <= '0;
        sum        <= '0;
        word_count <= '0;
      end
      case (state)
        LEN_HI: if (accept) len_hi <= rx_data;
        LEN_LO: if (accept) len <= len_rx;
        DATA: begin
          if (accept) begin
            sum  <= sum + rx_data;
            word <= word_shifted;
            // The strobe is registered here so it lands in the WRITE cycle,
            // one cycle after the last byte, with data that then holds.
            if (byte_idx == LAST_BYTE) begin
              byte_idx    <= '0;
              mem_we      <= 1'b1;
              mem_data    <= word_shifted;
              mem_address <= addr;
            end else begin
              byte_idx <= byte_idx + IW'(1);
            end
          end
        end
        WRITE: begin
          addr       <= addr + ADDR_WIDTH'(1);
          word_count <= word_count + (ADDR_WIDTH + 1)'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
